fetch_unit: RTL and testbench

Instruction fetch stage of the RV32 core; sits directly upstream of the decoder. Holds the PC, issues one-outstanding word requests to instruction memory, and buffers returned words with their PCs in a small FIFO. Presents `{inst_out, inst_pc}` to the decoder under a valid/ready handshake. Flushes and restarts on a branch/jump redirect.

---
 rtl/fetch_unit.sv | 148 ++++++++++++++
 tb/tb_fetch_unit.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: RV32 fetch stage with one outstanding imem request and a DEPTH-entry {inst, pc} FIFO.
// Optional FETCH_MISALIGN_EN: misaligned redirect targets raise fetch_misalign and halt fetch.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        nRst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  output logic        fetch_misalign
);
  localparam int unsigned   AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned   CW      = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [31:0]   NOP     = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_e;

  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   hold_addr_q, hold_addr_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic          halt_q, halt_d;
  logic [31:0]   fifo_inst_q [DEPTH];
  logic [31:0]   fifo_inst_d [DEPTH];
  logic [31:0]   fifo_pc_q   [DEPTH];
  logic [31:0]   fifo_pc_d   [DEPTH];

  logic [31:0]   target_pc;
  logic          target_bad;
  logic          pop;
  logic          push;
  logic          space;

`ifdef FETCH_MISALIGN_EN
  assign target_pc      = redirect_pc;
  assign target_bad     = |redirect_pc[1:0];
  assign fetch_misalign = halt_q;
`else
  assign target_pc      = redirect_pc & 32'hFFFF_FFFC;
  assign target_bad     = 1'b0;
  assign fetch_misalign = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    hold_addr_d = hold_addr_q;
    halt_d      = halt_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    fifo_inst_d = fifo_inst_q;
    fifo_pc_d   = fifo_pc_q;
    push        = 1'b0;

    imem_req   = (state_q != IDLE);
    imem_addr  = (state_q == DROP) ? hold_addr_q : pc_q;
    inst_valid = (count_q != '0);
    inst_out   = inst_valid ? fifo_inst_q[rd_ptr_q] : NOP;
    inst_pc    = inst_valid ? fifo_pc_q[rd_ptr_q] : 32'h0;
    pop        = inst_valid & inst_ready;
    space      = (count_q < DEPTH_C) | pop;

    if (redirect) begin
      // Redirect wins over everything; an unacked request must still drain through DROP.
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      pc_d     = target_pc;
      halt_d   = target_bad;
      unique case (state_q)
        REQ: begin
          if (imem_ack) begin
            state_d = target_bad ? IDLE : REQ;
          end else begin
            state_d     = DROP;
            hold_addr_d = pc_q;
          end
        end
        DROP: begin
          if (imem_ack) state_d = target_bad ? IDLE : REQ;
        end
        default: state_d = target_bad ? IDLE : REQ;
      endcase
    end else begin
      push = (state_q == REQ) && imem_ack;
      if (push) begin
        fifo_inst_d[wr_ptr_q] = imem_rdata;
        fifo_pc_d[wr_ptr_q]   = pc_q;
        wr_ptr_d              = wr_ptr_q + AW'(1);
        pc_d                  = pc_q + 32'd4;
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
      unique case (state_q)
        IDLE: begin
          if (space && !halt_q) state_d = REQ;
        end
        REQ: begin
          if (imem_ack) state_d = (count_d < DEPTH_C) ? REQ : IDLE;
        end
        DROP: begin
          if (imem_ack) state_d = halt_q ? IDLE : REQ;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      hold_addr_q <= RESET_PC;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      halt_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      hold_addr_q <= hold_addr_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      halt_q      <= halt_d;
    end
  end

  // Storage needs no reset: entries are only visible while count_q covers them.
  always_ff @(posedge clk) begin
    fifo_inst_q <= fifo_inst_d;
    fifo_pc_q   <= fifo_pc_d;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit with a latency-programmable memory model
// and a scoreboard of expected {pc, inst} pairs consumed as the decoder pops them.
`timescale 1ns/1ps
module tb_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        nRst = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        fetch_misalign;

  int checks = 0;
  int errors = 0;

  int   mem_lat = 0;
  logic mem_force = 1'b0;
  int   wait_cnt = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [31:0] target;
    int          lat;
    int          stall;
    int          n;
    logic [31:0] first_pc;
  } vec_t;
  vec_t vecs[5];

  logic        prev_pending = 1'b0;
  logic [31:0] prev_addr = 32'h0;

  fetch_unit dut (
    .clk            (clk),
    .nRst           (nRst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_out       (inst_out),
    .inst_pc        (inst_pc),
    .fetch_misalign (fetch_misalign)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_0001;
  endfunction

  // Memory acks once a request has waited mem_lat cycles; mem_force injects a stray ack.
  assign imem_ack   = mem_force | (imem_req && (wait_cnt >= mem_lat));
  assign imem_rdata = word_of(imem_addr);

  always @(posedge clk) begin
    if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
    else                       wait_cnt <= 0;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expectRun(input logic [31:0] first, input int n);
    logic [31:0] p;
    for (int i = 0; i < n; i++) begin
      p = first + 32'(4 * i);
      sb.push_back('{pc: p, inst: word_of(p)});
    end
  endtask

  task automatic waitDrain(input string name, input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    inst_ready = 1'b0;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s: %0d entries still expected after %0d cycles, required 0", name, sb.size(), budget);
      sb.delete();
    end
  endtask

  // Monitor: decoder-side pops against the scoreboard, plus request address stability.
  always @(negedge clk) begin
    exp_t e;
    if (nRst) begin
      if (prev_pending && imem_req) checkOutput("addr_stable", imem_addr, prev_addr);
      if (inst_valid && inst_ready && !redirect) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_pop: got pc=%h inst=%h, required no instruction", inst_pc, inst_out);
        end else begin
          e = sb.pop_front();
          checkOutput("pop_pc", inst_pc, e.pc);
          checkOutput("pop_inst", inst_out, e.inst);
        end
      end
      prev_pending <= imem_req && !imem_ack;
      prev_addr    <= imem_addr;
    end else begin
      prev_pending <= 1'b0;
    end
  end

  task automatic applyStimulus(input vec_t v);
    mem_lat     = v.lat;
    inst_ready  = 1'b0;
    redirect    = 1'b1;
    redirect_pc = v.target;
    sb.delete();
    expectRun(v.first_pc, v.n);
    tick();
    redirect = 1'b0;
    checkOutput("vec_flush_valid", inst_valid, 0);
    checkOutput("vec_misalign", fetch_misalign, 0);
    if (v.stall > 0) begin
      repeat (v.stall) tick();
      checkOutput("vec_stall_valid", inst_valid, 1);
      checkOutput("vec_stall_head", inst_pc, v.first_pc);
    end
    inst_ready = 1'b1;
    waitDrain("vec_drain", 100);
  endtask

  initial begin
    int n;
    vecs[0] = '{target: 32'h0000_0100, lat: 3, stall: 0, n: 4, first_pc: 32'h0000_0100};
    vecs[1] = '{target: 32'h0000_0200, lat: 0, stall: 4, n: 5, first_pc: 32'h0000_0200};
    vecs[2] = '{target: 32'hFFFF_FFF8, lat: 1, stall: 0, n: 4, first_pc: 32'hFFFF_FFF8};
    vecs[3] = '{target: 32'h0000_1000, lat: 2, stall: 4, n: 6, first_pc: 32'h0000_1000};
`ifdef FETCH_MISALIGN_EN
    vecs[4] = '{target: 32'h0000_0104, lat: 0, stall: 0, n: 3, first_pc: 32'h0000_0104};
`else
    vecs[4] = '{target: 32'h0000_0102, lat: 0, stall: 0, n: 3, first_pc: 32'h0000_0100};
`endif

    // Reset values
    nRst = 1'b0;
    repeat (3) tick();
    checkOutput("rst_req", imem_req, 0);
    checkOutput("rst_valid", inst_valid, 0);
    checkOutput("rst_inst", inst_out, NOP);
    checkOutput("rst_pc", inst_pc, 0);
    checkOutput("rst_misalign", fetch_misalign, 0);

    // Zero-wait fetch from RESET_PC, stalled decoder fills the FIFO, then releases
    nRst = 1'b1;
    expectRun(32'h0, 8);
    checkOutput("idle_after_rst", imem_req, 0);
    tick();
    checkOutput("first_req", imem_req, 1);
    checkOutput("first_addr", imem_addr, 32'h0);
    tick();
    checkOutput("first_valid", inst_valid, 1);
    checkOutput("first_pc", inst_pc, 32'h0);
    repeat (4) tick();
    checkOutput("full_req_low", imem_req, 0);
    checkOutput("full_head_pc", inst_pc, 32'h0);
    inst_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      checkOutput("consecutive_pc", inst_pc, 32'(4 * k));
    end
    waitDrain("initial_drain", 50);

    for (int i = 0; i < 5; i++) applyStimulus(vecs[i]);

    // Redirect in the first wait cycle of a slow request: old word must be dropped
    mem_lat     = 0;
    inst_ready  = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0300;
    sb.delete();
    tick();
    redirect = 1'b0;
    mem_lat  = 3;
    checkOutput("slow_req_addr", imem_addr, 32'h0000_0300);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0100;
    expectRun(32'h0000_0100, 3);
    tick();
    redirect = 1'b0;
    checkOutput("drop_req", imem_req, 1);
    checkOutput("drop_hold_addr", imem_addr, 32'h0000_0300);
    checkOutput("drop_valid", inst_valid, 0);
    n = 0;
    while (!(imem_req && imem_addr == 32'h0000_0100) && n < 20) begin
      tick();
      n++;
    end
    checkOutput("drop_new_addr", imem_addr, 32'h0000_0100);
    waitDrain("drop_drain", 60);

    // Redirect coinciding with an ack and a pop
    mem_lat     = 0;
    inst_ready  = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0400;
    sb.delete();
    expectRun(32'h0000_0400, 1);
    tick();
    redirect = 1'b0;
    repeat (4) tick();
    checkOutput("b_full_req", imem_req, 0);
    inst_ready = 1'b1;
    tick();
    checkOutput("b_refill_req", imem_req, 1);
    checkOutput("b_refill_addr", imem_addr, 32'h0000_0408);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    sb.delete();
    expectRun(32'h0000_0200, 3);
    tick();
    redirect = 1'b0;
    checkOutput("b_flush_valid", inst_valid, 0);
    checkOutput("b_redir_req", imem_req, 1);
    checkOutput("b_redir_addr", imem_addr, 32'h0000_0200);
    waitDrain("b_drain", 40);

    // Reset during an outstanding request, then a stray ack while IDLE
    mem_lat     = 5;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0500;
    sb.delete();
    tick();
    redirect = 1'b0;
    repeat (2) tick();
    nRst = 1'b0;
    sb.delete();
    tick();
    checkOutput("c_rst_req", imem_req, 0);
    checkOutput("c_rst_valid", inst_valid, 0);
    nRst      = 1'b1;
    mem_lat   = 0;
    mem_force = 1'b1;
    tick();
    mem_force = 1'b0;
    checkOutput("c_late_ack_ignored", inst_valid, 0);
    checkOutput("c_restart_req", imem_req, 1);
    checkOutput("c_restart_addr", imem_addr, 32'h0);
    expectRun(32'h0, 3);
    inst_ready = 1'b1;
    waitDrain("c_drain", 40);

`ifdef FETCH_MISALIGN_EN
    // Misaligned target halts fetch until an aligned redirect
    mem_lat     = 0;
    inst_ready  = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0102;
    sb.delete();
    tick();
    redirect = 1'b0;
    checkOutput("mis_flag_set", fetch_misalign, 1);
    checkOutput("mis_valid", inst_valid, 0);
    repeat (3) tick();
    checkOutput("mis_no_req", imem_req, 0);
    checkOutput("mis_flag_hold", fetch_misalign, 1);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0104;
    expectRun(32'h0000_0104, 3);
    tick();
    redirect = 1'b0;
    checkOutput("mis_flag_clear", fetch_misalign, 0);
    checkOutput("mis_resume_req", imem_req, 1);
    checkOutput("mis_resume_addr", imem_addr, 32'h0000_0104);
    waitDrain("mis_drain", 40);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
